controle_jogo_param: RTL and testbench

Parametrised control unit for the sequence-memory game: it drives the address counter, round counter, per-play timeout and lives counter internally, instead of relying on separate datapath counters. It sits between the input edge detector and the datapath (sequence ROM, play register, comparator). It supports two modes:
- **Progressive rounds:** round k replays entries 0..k.
- **Full sequence:** every play covers entries 0..n_rodadas.

A configurable number of lives lets the player replay a round after an error or timeout.

---
 rtl/controle_jogo_param.sv | 148 ++++++++++++++
 tb/tb_controle_jogo_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_jogo_param.sv
// Control unit for the sequence-memory game.
// Owns the address, round, timeout and lives counters.
module controle_jogo_param #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int LIVES       = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       jogada,
  input  logic                       igual,
  input  logic                       modo,
  input  logic [ADDR_W-1:0]          n_rodadas,
  output logic [ADDR_W-1:0]          endereco,
  output logic [ADDR_W-1:0]          rodada,
  output logic [$clog2(LIVES+1)-1:0] vidas,
  output logic                       zeraR,
  output logic                       registraR,
  output logic                       acertou,
  output logic                       errou,
  output logic                       timeout_ocorreu,
  output logic                       pronto,
  output logic [3:0]                 db_estado
);

  localparam int VW = $clog2(LIVES+1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC-1);
  localparam logic [VW-1:0] V_INIT = VW'(LIVES);
  localparam logic [VW-1:0] V_ONE  = VW'(1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    NOVA_RODADA = 4'd2,
    ESPERA      = 4'd4,
    REGISTRA    = 4'd5,
    COMPARA     = 4'd6,
    PROXIMA     = 4'd7,
    FIM_RODADA  = 4'd8,
    PERDE_VIDA  = 4'd9,
    ERRO        = 4'd14,
    ACERTO      = 4'd15
  } estado_t;

  estado_t estado, prox;

  logic [TW-1:0]     timer;
  logic              modo_r;
  logic [ADDR_W-1:0] nrod_r;
  logic              to_mark;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL:     if (iniciar) prox = PREPARA;
      PREPARA:     prox = NOVA_RODADA;
      NOVA_RODADA: prox = ESPERA;
      ESPERA: begin
        if (jogada)               prox = REGISTRA;
        else if (timer == T_LAST) prox = PERDE_VIDA;
      end
      REGISTRA:    prox = COMPARA;
      COMPARA: begin
        if (!igual)                 prox = PERDE_VIDA;
        else if (endereco == rodada) prox = FIM_RODADA;
        else                        prox = PROXIMA;
      end
      PROXIMA:     prox = ESPERA;
      FIM_RODADA: begin
        if (modo_r || rodada == nrod_r) prox = ACERTO;
        else                            prox = NOVA_RODADA;
      end
      PERDE_VIDA: begin
        if (vidas <= V_ONE) prox = ERRO;
        else                prox = NOVA_RODADA;
      end
      ACERTO, ERRO: if (iniciar) prox = PREPARA;
      default:     prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco        <= '0;
      rodada          <= '0;
      vidas           <= '0;
      timer           <= '0;
      modo_r          <= 1'b0;
      nrod_r          <= '0;
      to_mark         <= 1'b0;
      timeout_ocorreu <= 1'b0;
    end else begin
      unique case (estado)
        PREPARA: begin
          modo_r          <= modo;
          nrod_r          <= n_rodadas;
          endereco        <= '0;
          vidas           <= V_INIT;
          to_mark         <= 1'b0;
          timeout_ocorreu <= 1'b0;
          rodada          <= modo ? n_rodadas : '0;
        end
        NOVA_RODADA: begin
          endereco <= '0;
          timer    <= '0;
          to_mark  <= 1'b0;
        end
        ESPERA: begin
          if (!jogada) begin
            if (timer == T_LAST) to_mark <= 1'b1;
            else                 timer <= timer + TW'(1);
          end
        end
        PROXIMA: begin
          endereco <= endereco + ADDR_W'(1);
          timer    <= '0;
        end
        FIM_RODADA: begin
          if (!modo_r && rodada != nrod_r)
            rodada <= rodada + ADDR_W'(1);
        end
        PERDE_VIDA: begin
          // replays restart the same round from its first address
          endereco <= '0;
          if (vidas != '0) vidas <= vidas - V_ONE;
          if (vidas <= V_ONE) timeout_ocorreu <= to_mark;
        end
        default: ;
      endcase
    end
  end

  assign zeraR     = (estado == INICIAL) || (estado == PREPARA) ||
                     (estado == NOVA_RODADA);
  assign registraR = (estado == REGISTRA);
  assign acertou   = (estado == ACERTO);
  assign errou     = (estado == ERRO);
  assign pronto    = acertou | errou;
  assign db_estado = estado;

endmodule

// File: tb/tb_controle_jogo_param.sv
// Scoreboard bench for controle_jogo_param.
// Plays and game endings are checked by a monitor process.
module tb_controle_jogo_param;

  logic       clock, reset, iniciar, jogada, igual, modo;
  logic [3:0] n_rodadas, endereco, rodada, db_estado;
  logic [1:0] vidas;
  logic       zeraR, registraR, acertou, errou, timeout_ocorreu, pronto;

  controle_jogo_param #(
    .ADDR_W(4), .TIMEOUT_CYC(8), .LIVES(2)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .modo(modo), .n_rodadas(n_rodadas),
    .endereco(endereco), .rodada(rodada), .vidas(vidas),
    .zeraR(zeraR), .registraR(registraR), .acertou(acertou),
    .errou(errou), .timeout_ocorreu(timeout_ocorreu), .pronto(pronto),
    .db_estado(db_estado)
  );

  typedef struct { int e; int r; int v; } play_t;
  typedef struct { int st; int ac; int er; int to; int v; } end_t;

  play_t pq[$];
  end_t  eq[$];
  int vecs = 0;
  int errs = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget,
                            input string nm);
    int n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, db_estado, s);
  endtask

  task automatic start(input bit m, input int n);
    @(negedge clock);
    modo = m;
    n_rodadas = 4'(n);
    iniciar = 1'b1;
    @(negedge clock);
    chk("start_prepara", db_estado, 1);
    iniciar = 1'b0;
    @(negedge clock);
    chk("start_nova", db_estado, 2);
    chk("start_vidas", vidas, 2);
    chk("start_to_clear", timeout_ocorreu, 0);
    chk("start_rodada", rodada, m ? n : 0);
    @(negedge clock);
    chk("start_espera", db_estado, 4);
  endtask

  task automatic play(input bit ok, input int e, input int r,
                      input int v);
    pq.push_back('{e, r, v});
    wait_state(4, 40, "wait_espera");
    jogada = 1'b1;
    igual = ok;
    @(negedge clock);
    jogada = 1'b0;
  endtask

  initial begin
    play_t p;
    end_t  x;
    logic  pp = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) pp = 1'b0;
      else begin
        if (registraR) begin
          if (pq.size() == 0) chk("play_unexpected", 1, 0);
          else begin
            p = pq.pop_front();
            chk("play_endereco", endereco, p.e);
            chk("play_rodada", rodada, p.r);
            chk("play_vidas", vidas, p.v);
          end
        end
        if (pronto && !pp) begin
          if (eq.size() == 0) chk("end_unexpected", 1, 0);
          else begin
            x = eq.pop_front();
            chk("end_estado", db_estado, x.st);
            chk("end_acertou", acertou, x.ac);
            chk("end_errou", errou, x.er);
            chk("end_timeout", timeout_ocorreu, x.to);
            chk("end_vidas", vidas, x.v);
          end
        end
        pp = pronto;
      end
    end
  end

  initial begin
    reset = 1'b1;
    iniciar = 1'b0;
    jogada = 1'b0;
    igual = 1'b0;
    modo = 1'b0;
    n_rodadas = '0;
    #2;
    chk("rst_estado", db_estado, 0);
    chk("rst_zeraR", zeraR, 1);
    chk("rst_endereco", endereco, 0);
    chk("rst_rodada", rodada, 0);
    chk("rst_vidas", vidas, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_registraR", registraR, 0);
    chk("rst_timeout", timeout_ocorreu, 0);
    @(negedge clock);
    reset = 1'b0;

    // progressive win; mid-game input changes must be ignored
    start(0, 3);
    modo = 1'b1;
    n_rodadas = 4'd9;
    eq.push_back('{15, 1, 0, 0, 2});
    for (int r = 0; r <= 3; r++)
      for (int e = 0; e <= r; e++) play(1, e, r, 2);
    wait_state(15, 20, "win_acerto");
    chk("win_pronto", pronto, 1);
    chk("win_endereco", endereco, 3);
    chk("win_rodada", rodada, 3);

    // full-sequence mode
    start(1, 3);
    eq.push_back('{15, 1, 0, 0, 2});
    for (int e = 0; e <= 3; e++) play(1, e, 3, 2);
    wait_state(15, 20, "full_acerto");

    // wrong play at round 1 address 1, replay with one life left
    start(0, 3);
    eq.push_back('{15, 1, 0, 0, 1});
    play(1, 0, 0, 2);
    play(1, 0, 1, 2);
    play(0, 1, 1, 2);
    wait_state(2, 10, "replay_nova");
    chk("replay_endereco", endereco, 0);
    chk("replay_rodada", rodada, 1);
    chk("replay_vidas", vidas, 1);
    for (int r = 1; r <= 3; r++)
      for (int e = 0; e <= r; e++) play(1, e, r, 1);
    wait_state(15, 20, "replay_acerto");

    // jogada on the expiry cycle wins; n_rodadas=0 is one play
    start(0, 0);
    eq.push_back('{15, 1, 0, 0, 2});
    repeat (7) begin
      @(negedge clock);
      chk("expiry_hold", db_estado, 4);
    end
    play(1, 0, 0, 2);
    chk("expiry_registra", db_estado, 5);
    wait_state(15, 10, "expiry_acerto");

    // two timeouts lose the game
    start(0, 3);
    eq.push_back('{14, 0, 1, 1, 0});
    repeat (7) begin
      @(negedge clock);
      chk("timeout_hold", db_estado, 4);
    end
    @(negedge clock);
    chk("timeout_perde", db_estado, 9);
    chk("timeout_vidas", vidas, 2);
    wait_state(14, 40, "timeout_erro");

    // restart from ERRO with a new limit
    start(0, 1);
    eq.push_back('{15, 1, 0, 0, 2});
    play(1, 0, 0, 2);
    play(1, 0, 1, 2);
    play(1, 1, 1, 2);
    wait_state(15, 20, "restart_acerto");
    chk("restart_rodada", rodada, 1);

    // asynchronous reset while in COMPARA
    start(0, 3);
    play(1, 0, 0, 2);
    play(1, 0, 1, 2);
    play(1, 1, 1, 2);
    wait_state(6, 5, "mid_compara");
    #2 reset = 1'b1;
    #1;
    chk("mid_estado", db_estado, 0);
    chk("mid_endereco", endereco, 0);
    chk("mid_rodada", rodada, 0);
    chk("mid_vidas", vidas, 0);
    chk("mid_zeraR", zeraR, 1);
    chk("mid_registraR", registraR, 0);
    chk("mid_pronto", pronto, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid_idle", db_estado, 0);

    chk("pq_empty", pq.size(), 0);
    chk("eq_empty", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
